// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared PC width, reset vector and branch-type encoding
package risc_pkg;

  localparam int PC_W = 16;
  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    GT   = 2'd1,
    LE   = 2'd2,
    EQ   = 2'd3
  } br_type_e;

  // The decoder raises at most one flag; priority only matters for illegal combinations.
  function automatic br_type_e encode_br(input logic gt, input logic le, input logic eq);
    if (gt)      return GT;
    else if (le) return LE;
    else if (eq) return EQ;
    else         return NONE;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - EX-stage signed compare qualified by the registered branch type
module branch_cmp #(
  parameter int PC_W = risc_pkg::PC_W
) (
  input  logic [1:0]      br_type_i,
  input  logic [PC_W-1:0] cmp_a_i,
  input  logic [PC_W-1:0] cmp_b_i,
  output logic            taken_o
);
  import risc_pkg::*;

  logic signed [PC_W-1:0] a_s;
  logic signed [PC_W-1:0] b_s;

  assign a_s = cmp_a_i;
  assign b_s = cmp_b_i;

  always_comb begin
    taken_o = 1'b0;
    case (br_type_e'(br_type_i))
      GT:      taken_o = (a_s > b_s);
      LE:      taken_o = (a_s <= b_s);
      EQ:      taken_o = (a_s == b_s);
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - fetch PC, ID jump and EX branch redirect with stall handling
// Optional taken/jump statistics counters under BRANCH_STATS_EN.
module branch_pc_unit #(
  parameter int              PC_W     = risc_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(risc_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            jump,
  input  logic            gt_bra,
  input  logic            le_bra,
  input  logic            eq_bra,
  input  logic [PC_W-1:0] jump_target,
  input  logic [PC_W-1:0] bra_target,
  input  logic [PC_W-1:0] cmp_a,
  input  logic [PC_W-1:0] cmp_b,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus1,
  output logic            pcsrc1,
`ifdef BRANCH_STATS_EN
  output logic            pcsrc2,
  output logic [15:0]     taken_cnt,
  output logic [15:0]     jump_cnt
`else
  output logic            pcsrc2
`endif
);
  import risc_pkg::*;

  logic [PC_W-1:0] pc_q, pc_d;
  br_type_e        ex_type_q, ex_type_d;
  logic [PC_W-1:0] ex_target_q, ex_target_d;
  logic            taken;

  branch_cmp #(.PC_W(PC_W)) u_cmp (
    .br_type_i (ex_type_q),
    .cmp_a_i   (cmp_a),
    .cmp_b_i   (cmp_b),
    .taken_o   (taken)
  );

  assign pc       = pc_q;
  assign pc_plus1 = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  assign pcsrc2   = taken;
  // The older EX branch wins over the ID jump; a stalled jump waits for release.
  assign pcsrc1   = jump & ~taken & ~stall;

  always_comb begin
    pc_d        = pc_plus1;
    ex_type_d   = encode_br(gt_bra, le_bra, eq_bra);
    ex_target_d = bra_target;
    if (taken)       pc_d = ex_target_q;
    else if (pcsrc1) pc_d = jump_target;
    else if (stall)  pc_d = pc_q;
    // Bubble keeps the old target so only the flags need clearing.
    if (stall || taken) begin
      ex_type_d   = NONE;
      ex_target_d = ex_target_q;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q;
  logic [15:0] jump_cnt_q;

  assign taken_cnt = taken_cnt_q;
  assign jump_cnt  = jump_cnt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      ex_type_q   <= NONE;
      ex_target_q <= '0;
`ifdef BRANCH_STATS_EN
      taken_cnt_q <= 16'h0000;
      jump_cnt_q  <= 16'h0000;
`endif
    end else begin
      pc_q        <= pc_d;
      ex_type_q   <= ex_type_d;
      ex_target_q <= ex_target_d;
`ifdef BRANCH_STATS_EN
      if (taken && (taken_cnt_q != 16'hFFFF)) taken_cnt_q <= taken_cnt_q + 16'h0001;
      if (pcsrc1 && (jump_cnt_q != 16'hFFFF)) jump_cnt_q  <= jump_cnt_q + 16'h0001;
`endif
    end
  end

endmodule
